// File: rtl/decode_wb_if.sv
// decode_wb_if: groups the fetch inputs, D/E register outputs, writeback
// inputs and register-file observation outputs of decode_wb_stage.
interface decode_wb_if;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;

  logic [2:0]  d_stat;
  logic [3:0]  d_icode;
  logic [3:0]  d_ifun;
  logic [3:0]  d_rA;
  logic [3:0]  d_rB;
  logic [63:0] d_valC;
  logic [63:0] d_valP;
  logic [63:0] d_valA;
  logic [63:0] d_valB;

  logic [3:0]  w_icode;
  logic [3:0]  w_rA;
  logic [3:0]  w_rB;
  logic        w_cnd;
  logic [63:0] w_valE;
  logic [63:0] w_valM;

  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valC;
  logic [63:0] e_valA;
  logic [63:0] e_valB;

  logic [63:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4;
  logic [63:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9;
  logic [63:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14;

  modport master (
    output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM,
    input  d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
    input  e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB,
    input  reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
    input  reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
    input  reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
  );

  modport slave (
    input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM,
    output d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
    output e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB,
    output reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
    output reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
    output reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
  );
endinterface

// File: rtl/decode_wb_stage.sv
// decode_wb_stage: D pipeline register, 15 x 64-bit register file with
// combinational reads and writeback writes, and the E pipeline register.
// Optional macro DECODE_WB_BYPASS_EN: forwards same-cycle writeback values
// to the decode read ports (w_valM before w_valE); when undefined a read
// during a write returns the old register contents.
module decode_wb_stage (
  input  logic         clk,
  input  logic         reset,
  decode_wb_if.slave   bus
);
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [2:0] STAT_AOK = 3'b001;
  localparam logic [3:0] I_NOP    = 4'h1;

  logic [63:0] regs_r [0:14];
  logic [3:0]  src_a_s, src_b_s, dst_e_s, dst_m_s;
  logic [63:0] val_a_s, val_b_s;

  // Source register selection for the instruction held in D.
  always_comb begin
    src_a_s = REG_NONE;
    src_b_s = REG_NONE;
    case (bus.d_icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a_s = bus.d_rA;
      4'h9, 4'hB:             src_a_s = REG_RSP;
      default:                src_a_s = REG_NONE;
    endcase
    case (bus.d_icode)
      4'h4, 4'h5, 4'h6:       src_b_s = bus.d_rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b_s = REG_RSP;
      default:                src_b_s = REG_NONE;
    endcase
  end

  // Destination register selection for the instruction in writeback.
  always_comb begin
    dst_e_s = REG_NONE;
    dst_m_s = REG_NONE;
    case (bus.w_icode)
      4'h3, 4'h6:             dst_e_s = bus.w_rB;
      4'h2: begin
        if (bus.w_cnd) dst_e_s = bus.w_rB;
        else           dst_e_s = REG_NONE;
      end
      4'h8, 4'h9, 4'hA, 4'hB: dst_e_s = REG_RSP;
      default:                dst_e_s = REG_NONE;
    endcase
    case (bus.w_icode)
      4'h5, 4'hB: dst_m_s = bus.w_rA;
      default:    dst_m_s = REG_NONE;
    endcase
  end

  // Register-file read ports, optionally forwarding the current writeback.
  always_comb begin
    val_a_s = 64'd0;
    val_b_s = 64'd0;
    if (src_a_s == REG_NONE) val_a_s = 64'd0;
`ifdef DECODE_WB_BYPASS_EN
    else if (src_a_s == dst_m_s) val_a_s = bus.w_valM;
    else if (src_a_s == dst_e_s) val_a_s = bus.w_valE;
`endif
    else val_a_s = regs_r[src_a_s];
    if (src_b_s == REG_NONE) val_b_s = 64'd0;
`ifdef DECODE_WB_BYPASS_EN
    else if (src_b_s == dst_m_s) val_b_s = bus.w_valM;
    else if (src_b_s == dst_e_s) val_b_s = bus.w_valE;
`endif
    else val_b_s = regs_r[src_b_s];
  end

  assign bus.d_valA = val_a_s;
  assign bus.d_valB = val_b_s;

  // Register-file writes; the M write comes last so it wins on dstE == dstM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs_r[i] <= 64'd0;
    end else begin
      if (dst_e_s != REG_NONE) regs_r[dst_e_s] <= bus.w_valE;
      if (dst_m_s != REG_NONE) regs_r[dst_m_s] <= bus.w_valM;
    end
  end

  // D register: loads a bubble on reset, otherwise the fetch values every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.d_stat  <= STAT_AOK;
      bus.d_icode <= I_NOP;
      bus.d_ifun  <= 4'h0;
      bus.d_rA    <= REG_NONE;
      bus.d_rB    <= REG_NONE;
      bus.d_valC  <= 64'd0;
      bus.d_valP  <= 64'd0;
    end else begin
      bus.d_stat  <= bus.f_stat;
      bus.d_icode <= bus.f_icode;
      bus.d_ifun  <= bus.f_ifun;
      bus.d_rA    <= bus.f_rA;
      bus.d_rB    <= bus.f_rB;
      bus.d_valC  <= bus.f_valC;
      bus.d_valP  <= bus.f_valP;
    end
  end

  // E register: loads a bubble on reset, otherwise the decoded D values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.e_stat  <= STAT_AOK;
      bus.e_icode <= I_NOP;
      bus.e_ifun  <= 4'h0;
      bus.e_valC  <= 64'd0;
      bus.e_valA  <= 64'd0;
      bus.e_valB  <= 64'd0;
    end else begin
      bus.e_stat  <= bus.d_stat;
      bus.e_icode <= bus.d_icode;
      bus.e_ifun  <= bus.d_ifun;
      bus.e_valC  <= bus.d_valC;
      bus.e_valA  <= val_a_s;
      bus.e_valB  <= val_b_s;
    end
  end

  assign bus.reg_mem0  = regs_r[0];
  assign bus.reg_mem1  = regs_r[1];
  assign bus.reg_mem2  = regs_r[2];
  assign bus.reg_mem3  = regs_r[3];
  assign bus.reg_mem4  = regs_r[4];
  assign bus.reg_mem5  = regs_r[5];
  assign bus.reg_mem6  = regs_r[6];
  assign bus.reg_mem7  = regs_r[7];
  assign bus.reg_mem8  = regs_r[8];
  assign bus.reg_mem9  = regs_r[9];
  assign bus.reg_mem10 = regs_r[10];
  assign bus.reg_mem11 = regs_r[11];
  assign bus.reg_mem12 = regs_r[12];
  assign bus.reg_mem13 = regs_r[13];
  assign bus.reg_mem14 = regs_r[14];
endmodule

// File: tb/tb_decode_wb_stage.sv
// tb_decode_wb_stage: scoreboard bench for decode_wb_stage. Expected values
// are pushed when stimulus is applied and compared once the DUT responds.
module tb_decode_wb_stage;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] VALC1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] VALP1 = 64'h0000_0000_0000_1A2B;

  logic clk;
  logic reset;
  decode_wb_if bus ();

  decode_wb_stage dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mreg [0:14];
  int          checks   = 0;
  int          failures = 0;

  // Compare one observed value against its expectation.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_obs(input int sel);
    case (sel)
      0:  return bus.d_valA;
      1:  return bus.d_valB;
      2:  return {60'd0, bus.d_icode};
      3:  return {60'd0, bus.d_rA};
      4:  return {61'd0, bus.e_stat};
      5:  return {60'd0, bus.e_icode};
      6:  return bus.e_valA;
      7:  return bus.e_valB;
      8:  return {60'd0, bus.d_ifun};
      9:  return bus.d_valC;
      10: return bus.d_valP;
      11: return bus.e_valC;
      12: return {61'd0, bus.d_stat};
      13: return {60'd0, bus.e_ifun};
      16: return bus.reg_mem0;
      17: return bus.reg_mem1;
      18: return bus.reg_mem2;
      19: return bus.reg_mem3;
      20: return bus.reg_mem4;
      21: return bus.reg_mem5;
      22: return bus.reg_mem6;
      23: return bus.reg_mem7;
      24: return bus.reg_mem8;
      25: return bus.reg_mem9;
      26: return bus.reg_mem10;
      27: return bus.reg_mem11;
      28: return bus.reg_mem12;
      29: return bus.reg_mem13;
      30: return bus.reg_mem14;
      default: return 64'hX;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_regs(input string pfx);
    for (int i = 0; i < 15; i++) push($sformatf("%s_reg%0d", pfx, i), 16 + i, mreg[i]);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, get_obs(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                    input logic cnd, input logic [63:0] vale, input logic [63:0] valm);
    bus.w_icode = icode; bus.w_rA = ra; bus.w_rB = rb;
    bus.w_cnd = cnd; bus.w_valE = vale; bus.w_valM = valm;
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] valc, input logic [63:0] valp);
    bus.f_stat = 3'b001; bus.f_icode = icode; bus.f_ifun = ifun;
    bus.f_rA = ra; bus.f_rB = rb; bus.f_valC = valc; bus.f_valP = valp;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    reset = 1'b1;
    fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    // a writeback during reset must be ignored
    wb(4'h3, 4'hF, 4'h2, 1'b0, 64'd99, 64'd0);
    tick(); tick();
    push("rst_d_icode", 2, 64'd1);
    push("rst_d_rA", 3, 64'hF);
    push("rst_e_stat", 4, 64'd1);
    push("rst_e_icode", 5, 64'd1);
    push("rst_d_valA", 0, 64'd0);
    push("rst_d_valB", 1, 64'd0);
    push_regs("rst");
    drain();

    // irmovq writeback
    reset = 1'b0;
    wb(4'h3, 4'hF, 4'h2, 1'b0, 64'd10, 64'd0);
    tick(); mreg[2] = 64'd10;
    push_regs("irmov"); drain();
    wb(4'h3, 4'hF, 4'h1, 1'b0, 64'd5, 64'd0);
    tick(); mreg[1] = 64'd5;

    // OPq decode then E capture
    wb(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    fetch(4'h6, 4'h3, 4'h1, 4'h2, VALC1, VALP1);
    tick();
    push("op_d_valA", 0, 64'd5);
    push("op_d_valB", 1, 64'd10);
    push("op_d_icode", 2, 64'd6);
    push("op_d_ifun", 8, 64'd3);
    push("op_d_valC", 9, VALC1);
    push("op_d_valP", 10, VALP1);
    push("op_d_stat", 12, 64'd1);
    drain();
    fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    tick();
    push("op_e_valA", 6, 64'd5);
    push("op_e_valB", 7, 64'd10);
    push("op_e_icode", 5, 64'd6);
    push("op_e_ifun", 13, 64'd3);
    push("op_e_valC", 11, VALC1);
    push("op_e_stat", 4, 64'd1);
    drain();

    // cmov not taken, then taken
    wb(4'h2, 4'hF, 4'h3, 1'b0, 64'd7, 64'd0);
    tick(); push_regs("cmov0"); drain();
    wb(4'h2, 4'hF, 4'h3, 1'b1, 64'd7, 64'd0);
    tick(); mreg[3] = 64'd7; push_regs("cmov1"); drain();

    // popq %rsp: valM wins
    wb(4'hB, 4'h4, 4'hF, 1'b0, 64'h80, 64'h55);
    tick(); mreg[4] = 64'h55; push_regs("poprsp"); drain();
    // popq %rbp: both ports write
    wb(4'hB, 4'h5, 4'hF, 1'b0, 64'h88, 64'h66);
    tick(); mreg[4] = 64'h88; mreg[5] = 64'h66; push_regs("poprbp"); drain();

    // halt, unused icode and OPq to none write nothing
    wb(4'h0, 4'h6, 4'h6, 1'b1, 64'h77, 64'h77); tick();
    wb(4'hC, 4'h6, 4'h6, 1'b1, 64'h77, 64'h77); tick();
    wb(4'hF, 4'h6, 4'h6, 1'b1, 64'h77, 64'h77); tick();
    wb(4'h6, 4'h6, 4'hF, 1'b1, 64'h77, 64'h77); tick();
    push_regs("nowrite"); drain();

    // call writes %rsp from valE
    wb(4'h8, 4'hF, 4'hF, 1'b0, 64'h100, 64'h0);
    tick(); mreg[4] = 64'h100; push_regs("call"); drain();
    wb(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);

    // mrmovq and call decode source selection
    fetch(4'h5, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    tick();
    push("mrm_d_valA", 0, 64'd0);
    push("mrm_d_valB", 1, mreg[2]);
    drain();
    fetch(4'h8, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    tick();
    push("call_d_valA", 0, 64'd0);
    push("call_d_valB", 1, mreg[4]);
    drain();

    // read during write on srcA
    fetch(4'h2, 4'h0, 4'h1, 4'hF, 64'd0, 64'd0);
    tick();
    push("rdw_pre_valA", 0, mreg[1]);
    drain();
    wb(4'h3, 4'hF, 4'h1, 1'b0, 64'd9, 64'd0);
    #1;
    push("rdw_valA", 0, BYP ? 64'd9 : mreg[1]);
    drain();
    tick(); mreg[1] = 64'd9;
    push("rdw_post_valA", 0, 64'd9);
    push_regs("rdw"); drain();

    // ret reads %rsp on both ports while popq %rsp writes it
    wb(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    fetch(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    tick();
    wb(4'hB, 4'h4, 4'hF, 1'b0, 64'hAA, 64'hBB);
    #1;
    push("prec_valA", 0, BYP ? 64'hBB : mreg[4]);
    push("prec_valB", 1, BYP ? 64'hBB : mreg[4]);
    drain();
    tick(); mreg[4] = 64'hBB;
    push_regs("prec"); drain();

    // mid-run reset clears everything despite a pending write
    reset = 1'b1;
    wb(4'h3, 4'hF, 4'h7, 1'b0, 64'h1234, 64'd0);
    fetch(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    tick();
    for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    push("rst2_d_icode", 2, 64'd1);
    push("rst2_d_rA", 3, 64'hF);
    push_regs("rst2"); drain();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_wb_stage.md
DECODE_WB_STAGE -- requirements
Module: decode_wb_stage

Interface
- REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
- REQ-003 SHALL have inputs f_stat[2:0], f_icode[3:0], f_ifun[3:0], f_rA[3:0], f_rB[3:0], f_valC[63:0], f_valP[63:0]: fetch-stage values captured into the D register.
- REQ-004 SHALL have outputs d_stat[2:0], d_icode[3:0], d_ifun[3:0], d_rA[3:0], d_rB[3:0], d_valC[63:0], d_valP[63:0]: D register contents.
- REQ-005 SHALL have outputs d_valA[63:0] and d_valB[63:0]: combinational register-file read results for the D-stage instruction.
- REQ-006 SHALL have inputs w_icode[3:0], w_rA[3:0], w_rB[3:0], w_cnd (1 bit), w_valE[63:0] and w_valM[63:0]: writeback-stage instruction fields.
- REQ-007 SHALL have outputs e_stat[2:0], e_icode[3:0], e_ifun[3:0], e_valC[63:0], e_valA[63:0], e_valB[63:0]: E register contents.
- REQ-008 SHALL have outputs reg_mem0..reg_mem14, each [63:0]: live contents of registers 0..14, for observation.

Function
- REQ-009 SHALL use stat one-hot encoding {HLT,INS,AOK}, with 3'b001 = AOK.
- REQ-010 SHALL encode icodes as: 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- REQ-011 SHALL treat register ID 4 as %rsp and ID 0xF as "none".
- REQ-012 D register SHALL capture all f_* inputs at every rising edge when reset=0, giving 1-cycle latency.
- REQ-013 srcA SHALL be rA for icode 2/4/6/A, 4 for icode 9/B, and none otherwise.
- REQ-014 srcB SHALL be rB for icode 4/5/6, 4 for icode 8/9/A/B, and none otherwise.
- REQ-015 d_valA SHALL equal reg[srcA], or 0 when srcA is none; d_valB SHALL be derived likewise from srcB. Both SHALL be purely combinational.
- REQ-016 Register file SHALL hold 15 x 64-bit registers and be written at the rising edge.
- REQ-017 dstE SHALL be w_rB for icode 3/6, and for icode 2 only when w_cnd=1; it SHALL be 4 for icode 8/9/A/B, and none otherwise. reg[dstE] SHALL be loaded with w_valE.
- REQ-018 dstM SHALL be w_rA for icode 5/B, and none otherwise. reg[dstM] SHALL be loaded with w_valM.
- REQ-019 When dstE == dstM (e.g. popq %rsp), w_valM SHALL be written.
- REQ-020 Destination "none" SHALL cause no write.
- REQ-021 The unused icodes C..F and halt SHALL write nothing.
- REQ-022 E register SHALL capture d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB at every rising edge, giving 1-cycle latency from D.
- REQ-023 SHALL provide no stall or bubble control; both registers SHALL load every cycle.
- REQ-024 All arithmetic SHALL be absent; values SHALL pass through at 64 bits unmodified.

Reset
- REQ-025 While reset=1 at a rising edge, the D register SHALL load a bubble: d_stat=3'b001, d_icode=1, d_ifun=0, d_rA=d_rB=0xF, d_valC=d_valP=0.
- REQ-026 While reset=1 at a rising edge, the E register SHALL load: e_stat=3'b001, e_icode=1, e_ifun=0, and all e_val* = 0.
- REQ-027 While reset=1 at a rising edge, all 15 registers SHALL be set to 0.
- REQ-028 Reset SHALL take priority over writeback in the same cycle, so that no register write occurs.

Configuration
- REQ-029 The macro DECODE_WB_BYPASS_EN SHALL select the read-during-write behaviour.
- REQ-030 With DECODE_WB_BYPASS_EN defined, when srcA/srcB equals the current-cycle dstM or dstE, d_valA/d_valB SHALL return w_valM or w_valE respectively, with w_valM taking precedence.
- REQ-031 Without DECODE_WB_BYPASS_EN, a read during a same-cycle write SHALL return the old register value.

Verification
- REQ-032 Reset: after reset, d_icode=1, d_rA=0xF, e_stat=3'b001, reg_mem0..14=0, and d_valA=d_valB=0.
- REQ-033 irmovq writeback: apply w_icode=3, w_rB=2, w_valE=10 for one edge. Required: reg_mem2=10, and all other registers unchanged.
- REQ-034 OPq decode: with reg1=5 and reg2=10, present f_icode=6, f_rA=1, f_rB=2. Required: after one edge, d_valA=5 and d_valB=10; after a second edge, e_valA=5, e_valB=10, e_icode=6.
- REQ-035 cmov: apply w_icode=2, w_cnd=0, w_rB=3, w_valE=7. Required: reg3 unchanged. Repeat with w_cnd=1. Required: reg3=7.
- REQ-036 popq %rsp: apply w_icode=B, w_rA=4, w_valE=0x80, w_valM=0x55. Required: reg4=0x55.
- REQ-037 Read-during-write: apply w_icode=3, w_rB=1, w_valE=9 while d_rA=1, d_icode=2. Required: d_valA=9 in that cycle when DECODE_WB_BYPASS_EN is defined, and the old value otherwise.
